lcd_timing_gen: RTL
===================

// Module: lcd_timing_gen
// PURPOSE
// - RGB565 LCD timing generator for the 480x272 panel, driven by the 9 MHz pixel clock (PLL divided output).
// - Generates HSYNC/VSYNC/DE and fetches pixels from an upstream source over a 1-cycle-latency request port.
// - Drives the panel pins directly.
// PARAMETERS
// - H_SYNC 4, H_BP 39, H_ACTIVE 480, H_FP 2 : horizontal phases in pclk; H_TOTAL=525
// - V_SYNC 4, V_BP 8, V_ACTIVE 272, V_FP 4 : vertical phases in lines; V_TOTAL=288 (~59.5 Hz)
// - SYNC_ACT_LOW 1 : 1 = hsync/vsync active-low, 0 = active-high
// PORTS
// - clk          in   1   pixel clock (9 MHz), all logic on rising edge
// - rst_n        in   1   asynchronous active-low reset
// - en           in   1   run request; stop takes effect at frame end
// - pix_req      out  1   pixel request for (pix_x,pix_y)
// - pix_x        out  9   requested column 0..479
// - pix_y        out  9   requested row 0..271
// - pix_valid    in   1   upstream data valid, 1 clk after pix_req
// - pix_data     in   16  RGB565 {R[15:11],G[10:5],B[4:0]}
// - lcd_de       out  1   data enable
// - lcd_hsync    out  1   horizontal sync (polarity per SYNC_ACT_LOW)
// - lcd_vsync    out  1   vertical sync
// - lcd_r/g/b    out  5/6/5 pixel colour
// - frame_start  out  1   1-clk pulse, first clk of each frame at the pins
// - underflow    out  1   sticky: requested pixel not delivered
// BEHAVIOUR
// - Reset (async): state IDLE, h_cnt=v_cnt=0, pix_req=0, pix_x=pix_y=0, lcd_de=0, lcd_rgb=0, frame_start=0, underflow=0.
//   hsync/vsync at inactive level. Same values immediately on rst_n low mid-frame.
// - FSM IDLE/RUN/STOP:
//   - IDLE+en -> RUN; counters start at h=0,v=0 next clk.
//   - RUN+!en -> STOP.
//   - STOP: counts to h=H_TOTAL-1,v=V_TOTAL-1, then -> IDLE. en high in STOP -> RUN; frame continues with no gap.
//   - IDLE: counters held at 0; pipeline drains to idle values.
// - Counters: h_cnt 0..H_TOTAL-1 wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
//   Phase order per line/frame: SYNC, BP, ACTIVE, FP.
// - Stage 1 (registered from counters): pix_req=1 iff h in [H_SYNC+H_BP, +H_ACTIVE) and v in [V_SYNC+V_BP, +V_ACTIVE).
//   pix_x/pix_y = offsets into the active area; they hold their last value when pix_req=0.
// - Stage 2 (registered): lcd_de = stage-1 pix_req.
//   lcd_rgb = pix_data if pix_req_d1 & pix_valid; else 0.
//   hsync/vsync pass through both stages, so sync/DE/data stay aligned (2 clk after counter).
// - underflow is set when pix_req_d1 & !pix_valid; cleared only by reset. pix_valid without a request is ignored.
// - frame_start = stage-2 copy of (h==0 & v==0 & RUN/STOP).
// - Line at pins: 480 consecutive DE clocks; first DE at clk H_SYNC+H_BP+2 after the line's h=0.
// CONFIGURATION
// - LCD_TIMING_PATTERN_EN defined: adds input pattern_sel (1 bit).
//   - pattern_sel=1: pix_req forced 0, underflow not updated.
//   - Stage-2 rgb = 8 vertical colour bars of 60 px: white, yellow, cyan, green, magenta, red, blue, black (RGB565 full-scale).
//   - Timing unchanged.
// - LCD_TIMING_PATTERN_EN undefined: no pattern_sel port, no bar logic; pixels come only from pix_data.
// TESTING
// - Reset, en=1: lcd_hsync low for 4 clks every 525; lcd_vsync low for 4 lines every 288; 480 DE clks per active line; 272 active lines.
// - pix_valid echoes pix_req after 1 clk, pix_data={pix_y[6:0],pix_x}: each lcd_rgb matches its coordinate; underflow=0.
// - Drop pix_valid for pixel (100,50): that pixel outputs 0x0000, underflow=1 from the next clk, and stays 1 to frame end.
// - en low at v=100: frame finishes at v=287,h=524, then IDLE; no frame_start; de=0.
//   en high again in STOP: next frame follows back-to-back.
// - rst_n low at h=300,v=150: all outputs at reset values with no clk edge; the restart begins a clean frame.
// - With LCD_TIMING_PATTERN_EN, pattern_sel=1: pix_req=0; x=0..59 -> 0xFFFF, x=420..479 -> 0x0000.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// RGB565 TFT timing generator: sync/DE counters, pixel fetch over a 1-cycle-latency port, sync/DE/data aligned at the pins.
// Optional build macro LCD_TIMING_PATTERN_EN adds pattern_sel and an internal 8-bar colour test pattern.
module lcd_timing_gen #(
  parameter int H_SYNC       = 4,
  parameter int H_BP         = 39,
  parameter int H_ACTIVE     = 480,
  parameter int H_FP         = 2,
  parameter int V_SYNC       = 4,
  parameter int V_BP         = 8,
  parameter int V_ACTIVE     = 272,
  parameter int V_FP         = 4,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
`ifdef LCD_TIMING_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        pix_req,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_AS    = H_SYNC + H_BP;
  localparam int H_AE    = H_AS + H_ACTIVE;
  localparam int V_AS    = V_SYNC + V_BP;
  localparam int V_AE    = V_AS + V_ACTIVE;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  int            h_i, v_i;
  logic          running, h_last, v_last, in_active, pat_on;

  assign h_i       = int'(h_cnt);
  assign v_i       = int'(v_cnt);
  assign running   = (state != IDLE);
  assign h_last    = (h_i == H_TOTAL - 1);
  assign v_last    = (v_i == V_TOTAL - 1);
  assign in_active = running && (h_i >= H_AS) && (h_i < H_AE) && (v_i >= V_AS) && (v_i < V_AE);

`ifdef LCD_TIMING_PATTERN_EN
  assign pat_on = pattern_sel;
`else
  assign pat_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // A stop request only lets the current frame run out; en returning before the end resumes seamlessly.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en)                  state_nxt = RUN;
        else if (h_last && v_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (running) begin
      if (h_last) begin
        h_nxt = '0;
        v_nxt = v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end else begin
      h_nxt = '0;
      v_nxt = '0;
    end
  end

  logic act1, hs1, vs1, fs1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1    <= 1'b0;
      pix_req <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      fs1     <= 1'b0;
    end else begin
      act1    <= in_active;
      pix_req <= in_active && !pat_on;
      hs1     <= running && (h_i < H_SYNC);
      vs1     <= running && (v_i < V_SYNC);
      fs1     <= running && (h_i == 0) && (v_i == 0);
      if (in_active && !pat_on) begin
        pix_x <= 9'(h_i - H_AS);
        pix_y <= 9'(v_i - V_AS);
      end
    end
  end

  logic hs2, vs2, req2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de      <= 1'b0;
      hs2         <= 1'b0;
      vs2         <= 1'b0;
      frame_start <= 1'b0;
      req2        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      lcd_de      <= act1;
      hs2         <= hs1;
      vs2         <= vs1;
      frame_start <= fs1;
      req2        <= pix_req;
      if (req2 && !pix_valid) underflow <= 1'b1;
    end
  end

`ifdef LCD_TIMING_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  function automatic logic [15:0] bar_color(input logic [8:0] x);
    int idx;
    idx = int'(x) / BAR_W;
    case (idx)
      0:       bar_color = 16'hFFFF;
      1:       bar_color = 16'hFFE0;
      2:       bar_color = 16'h07FF;
      3:       bar_color = 16'h07E0;
      4:       bar_color = 16'hF81F;
      5:       bar_color = 16'hF800;
      6:       bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Separate column register: pix_x must hold while requests are suppressed.
  logic [8:0]  bar_x;
  logic        pat1, pat2;
  logic [15:0] bar2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_x <= '0;
      pat1  <= 1'b0;
      pat2  <= 1'b0;
      bar2  <= '0;
    end else begin
      if (in_active) bar_x <= 9'(h_i - H_AS);
      pat1 <= pattern_sel;
      pat2 <= pat1;
      bar2 <= act1 ? bar_color(bar_x) : 16'h0000;
    end
  end
`endif

  // Upstream data lands in the same cycle as DE, so the colour is gated from the pin-stage request.
  logic [15:0] rgb;

  always_comb begin
    rgb = 16'h0000;
    if (req2 && pix_valid) rgb = pix_data;
`ifdef LCD_TIMING_PATTERN_EN
    if (pat2) rgb = bar2;
`endif
  end

  assign {lcd_r, lcd_g, lcd_b} = rgb;
  assign lcd_hsync = SYNC_ACT_LOW ? ~hs2 : hs2;
  assign lcd_vsync = SYNC_ACT_LOW ? ~vs2 : vs2;

endmodule
